// File: rtl/noc_switch_allocator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : noc_switch_allocator                                          |
// | Desc     : Two-stage separable switch allocator with per-VC credits and  |
// |            wormhole output locking for the 5-port mesh router.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module noc_switch_allocator #(
  parameter  int PORTS    = 5,
  parameter  int VC_COUNT = 3,
  parameter  int CREDITS  = 4,
  localparam int PW       = $clog2(PORTS),
  localparam int VW       = $clog2(VC_COUNT),
  localparam int CW       = $clog2(CREDITS + 1),
  localparam int NR       = PORTS * VC_COUNT,
  localparam int RW       = $clog2(NR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NR-1:0]         req,
  input  logic [NR*PW-1:0]      req_port,
  input  logic [NR-1:0]         req_tail,
  input  logic [NR-1:0]         credit_return,
  output logic [NR-1:0]         grant,
  output logic [PORTS-1:0]      out_valid,
  output logic [PORTS*PW-1:0]   xbar_sel,
  output logic [PORTS*VW-1:0]   xbar_vc,
  output logic [NR*CW-1:0]      credit_count,
  output logic [PORTS-1:0]      out_locked,
  output logic                  credit_err
);

  logic [CW-1:0]       r_credit [PORTS][VC_COUNT];
  logic [PORTS-1:0]    r_lock;
  logic [RW-1:0]       r_owner   [PORTS];
  logic [VW-1:0]       r_in_ptr  [PORTS];
  logic [PW-1:0]       r_out_ptr [PORTS];
  logic                r_credit_err;

  logic [PW-1:0]       w_req_port [NR];
  logic [NR-1:0]       w_elig;
  logic                w_bad_port;
  logic [PORTS-1:0]    w_nom_vld;
  logic [VW-1:0]       w_nom_vc   [PORTS];
  logic [PW-1:0]       w_nom_port [PORTS];
  logic [PORTS-1:0]    w_out_vld;
  logic [PW-1:0]       w_sel [PORTS];
  logic [VW-1:0]       w_vc  [PORTS];
  logic [PORTS-1:0]    w_tail;
  logic [RW-1:0]       w_own [PORTS];
  logic [PORTS-1:0]    w_in_gnt;
  logic [NR-1:0]       w_grant;
  logic [VC_COUNT-1:0] w_dec [PORTS];
  logic                w_overflow;

  // Eligibility: valid route, credit available, output free or owned by us.
  always_comb begin
    w_elig     = '0;
    w_bad_port = 1'b0;
    for (int r = 0; r < NR; r++) begin
      w_req_port[r] = req_port[r*PW +: PW];
      if (req[r] && ({1'b0, w_req_port[r]} >= (PW+1)'(PORTS))) begin
        w_bad_port = 1'b1;
      end
    end
    for (int p = 0; p < PORTS; p++) begin
      for (int v = 0; v < VC_COUNT; v++) begin
        for (int o = 0; o < PORTS; o++) begin
          if (req[p*VC_COUNT+v] && (w_req_port[p*VC_COUNT+v] == PW'(o)) &&
              (r_credit[o][v] != '0) &&
              (!r_lock[o] || (r_owner[o] == RW'(p*VC_COUNT+v)))) begin
            w_elig[p*VC_COUNT+v] = 1'b1;
          end
        end
      end
    end
  end

  // Both round-robin searches use two passes: at/after the pointer, then wrapped.
  always_comb begin
    w_nom_vld = '0;
    w_out_vld = '0;
    w_tail    = '0;
    w_in_gnt  = '0;
    w_grant   = '0;
    for (int p = 0; p < PORTS; p++) begin
      w_nom_vc[p]   = '0;
      w_nom_port[p] = '0;
      for (int v = 0; v < VC_COUNT; v++) begin
        if (!w_nom_vld[p] && (v >= int'(r_in_ptr[p])) && w_elig[p*VC_COUNT+v]) begin
          w_nom_vld[p]  = 1'b1;
          w_nom_vc[p]   = VW'(v);
          w_nom_port[p] = w_req_port[p*VC_COUNT+v];
        end
      end
      for (int v = 0; v < VC_COUNT; v++) begin
        if (!w_nom_vld[p] && w_elig[p*VC_COUNT+v]) begin
          w_nom_vld[p]  = 1'b1;
          w_nom_vc[p]   = VW'(v);
          w_nom_port[p] = w_req_port[p*VC_COUNT+v];
        end
      end
    end
    for (int o = 0; o < PORTS; o++) begin
      w_sel[o] = '0;
      w_vc[o]  = '0;
      w_own[o] = '0;
      w_dec[o] = '0;
      for (int p = 0; p < PORTS; p++) begin
        if (!reset && !w_out_vld[o] && (p >= int'(r_out_ptr[o])) &&
            w_nom_vld[p] && (w_nom_port[p] == PW'(o))) begin
          w_out_vld[o] = 1'b1;
          w_sel[o]     = PW'(p);
          w_vc[o]      = w_nom_vc[p];
        end
      end
      for (int p = 0; p < PORTS; p++) begin
        if (!reset && !w_out_vld[o] && w_nom_vld[p] && (w_nom_port[p] == PW'(o))) begin
          w_out_vld[o] = 1'b1;
          w_sel[o]     = PW'(p);
          w_vc[o]      = w_nom_vc[p];
        end
      end
      for (int p = 0; p < PORTS; p++) begin
        for (int v = 0; v < VC_COUNT; v++) begin
          if (w_out_vld[o] && (w_sel[o] == PW'(p)) && (w_vc[o] == VW'(v))) begin
            w_grant[p*VC_COUNT+v] = 1'b1;
            w_in_gnt[p]           = 1'b1;
            w_tail[o]             = req_tail[p*VC_COUNT+v];
            w_own[o]              = RW'(p*VC_COUNT+v);
            w_dec[o][v]           = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_overflow = 1'b0;
    for (int o = 0; o < PORTS; o++) begin
      for (int v = 0; v < VC_COUNT; v++) begin
        if (credit_return[o*VC_COUNT+v] && !w_dec[o][v] && (r_credit[o][v] == CW'(CREDITS))) begin
          w_overflow = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock       <= '0;
      r_credit_err <= 1'b0;
      for (int o = 0; o < PORTS; o++) begin
        r_owner[o]   <= '0;
        r_in_ptr[o]  <= '0;
        r_out_ptr[o] <= '0;
        for (int v = 0; v < VC_COUNT; v++) begin
          r_credit[o][v] <= CW'(CREDITS);
        end
      end
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        if (w_out_vld[o]) begin
          r_out_ptr[o] <= (w_sel[o] == PW'(PORTS-1)) ? '0 : w_sel[o] + PW'(1);
          r_lock[o]    <= ~w_tail[o];
          if (!w_tail[o]) begin
            r_owner[o] <= w_own[o];
          end
        end
        if (w_in_gnt[o]) begin
          r_in_ptr[o] <= (w_nom_vc[o] == VW'(VC_COUNT-1)) ? '0 : w_nom_vc[o] + VW'(1);
        end
        // Simultaneous grant and return on the same (o,v) cancel out.
        for (int v = 0; v < VC_COUNT; v++) begin
          if (w_dec[o][v] && !credit_return[o*VC_COUNT+v]) begin
            r_credit[o][v] <= r_credit[o][v] - CW'(1);
          end else if (!w_dec[o][v] && credit_return[o*VC_COUNT+v] &&
                       (r_credit[o][v] != CW'(CREDITS))) begin
            r_credit[o][v] <= r_credit[o][v] + CW'(1);
          end
        end
      end
      if (w_overflow || w_bad_port) begin
        r_credit_err <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < PORTS; o++) begin
      xbar_sel[o*PW +: PW] = w_sel[o];
      xbar_vc[o*VW +: VW]  = w_vc[o];
      for (int v = 0; v < VC_COUNT; v++) begin
        credit_count[(o*VC_COUNT+v)*CW +: CW] = r_credit[o][v];
      end
    end
  end

  assign grant      = w_grant;
  assign out_valid  = w_out_vld;
  assign out_locked = r_lock;
  assign credit_err = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_switch_allocator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_noc_switch_allocator                                       |
// | Desc     : Scoreboard bench for the switch allocator.                    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_noc_switch_allocator;

  logic        clk = 1'b0;
  logic        reset;
  logic [14:0] req, req_tail, credit_return, grant;
  logic [44:0] req_port, credit_count;
  logic [4:0]  out_valid, out_locked;
  logic [14:0] xbar_sel;
  logic [9:0]  xbar_vc;
  logic        credit_err;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [14:0] g;
    logic [4:0]  ov;
    logic [14:0] sel;
    logic [9:0]  vc;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  noc_switch_allocator dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_port      (req_port),
    .req_tail      (req_tail),
    .credit_return (credit_return),
    .grant         (grant),
    .out_valid     (out_valid),
    .xbar_sel      (xbar_sel),
    .xbar_vc       (xbar_vc),
    .credit_count  (credit_count),
    .out_locked    (out_locked),
    .credit_err    (credit_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, ".grant"}, 64'(grant), 64'(e.g));
      chk({e.tag, ".ovalid"}, 64'(out_valid), 64'(e.ov));
      chk({e.tag, ".xsel"}, 64'(xbar_sel), 64'(e.sel));
      chk({e.tag, ".xvc"}, 64'(xbar_vc), 64'(e.vc));
    end
  end

  task automatic cyc(input string tag, input logic [14:0] g, input logic [4:0] ov,
                     input logic [14:0] sel, input logic [9:0] vc);
    exp_t e;
    e.tag = tag; e.g = g; e.ov = ov; e.sel = sel; e.vc = vc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input int port, input logic tail);
    req[r]             = 1'b1;
    req_port[r*3 +: 3] = 3'(port);
    req_tail[r]        = tail;
  endtask

  task automatic clr();
    req           = '0;
    req_tail      = '0;
    credit_return = '0;
  endtask

  function automatic logic [63:0] cred(input int i);
    return 64'(credit_count[i*3 +: 3]);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [14:0] gv, sv;
    reset = 1'b1;
    req = '0; req_port = '0; req_tail = '0; credit_return = '0;
    @(posedge clk); #1;

    // Reset state; requests must not leak through while reset is high
    set_req(12, 1, 1'b1);
    cyc("rst_gate", 15'h0, 5'h0, 15'h0, 10'h0);
    chk("rst_cred", 64'(credit_count), 64'({15{3'd4}}));
    chk("rst_lock", 64'(out_locked), 64'h0);
    chk("rst_err", 64'(credit_err), 64'h0);
    reset = 1'b0;

    // Credit exhaustion on output 1 VC0
    for (int i = 0; i < 6; i++) begin
      if (i < 4) cyc($sformatf("exh%0d", i), 15'h1000, 5'b00010, 15'h0020, 10'h0);
      else       cyc($sformatf("exh%0d", i), 15'h0000, 5'b00000, 15'h0000, 10'h0);
    end
    chk("exh_cred", cred(3), 64'd0);
    credit_return[3] = 1'b1;
    cyc("ret_wait", 15'h0, 5'h0, 15'h0, 10'h0);
    credit_return[3] = 1'b0;
    cyc("ret_use", 15'h1000, 5'b00010, 15'h0020, 10'h0);
    req = '0;
    credit_return[3] = 1'b1;
    for (int i = 0; i < 4; i++) cyc($sformatf("refill%0d", i), 15'h0, 5'h0, 15'h0, 10'h0);
    clr();
    chk("refill_cred", cred(3), 64'd4);

    // Output round-robin on output 4
    set_req(0, 4, 1'b1); set_req(6, 4, 1'b1); set_req(9, 4, 1'b1);
    credit_return[12] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int s;
      s  = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 2 : 3);
      gv = 15'd1 << (s * 3);
      sv = 15'(s) << 12;
      cyc($sformatf("orr%0d", i), gv, 5'b10000, sv, 10'h0);
    end
    clr();
    chk("orr_cred", cred(12), 64'd4);
    chk("orr_err", 64'(credit_err), 64'h0);

    // Wormhole lock on output 2
    set_req(4, 2, 1'b0); set_req(9, 2, 1'b1);
    cyc("wh_head", 15'h0010, 5'b00100, 15'h0040, 10'h010);
    chk("wh_locked", 64'(out_locked), 64'h04);
    cyc("wh_body", 15'h0010, 5'b00100, 15'h0040, 10'h010);
    req_tail[4] = 1'b1;
    cyc("wh_tail", 15'h0010, 5'b00100, 15'h0040, 10'h010);
    chk("wh_unlocked", 64'(out_locked), 64'h00);
    req[4] = 1'b0;
    cyc("wh_next", 15'h0200, 5'b00100, 15'h00C0, 10'h0);
    clr();
    chk("wh_cred", cred(7), 64'd1);

    // Input VC arbitration on input 0
    set_req(0, 1, 1'b1); set_req(2, 3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) cyc($sformatf("iarb%0d", i), 15'h0004, 5'b01000, 15'h0, 10'h080);
      else            cyc($sformatf("iarb%0d", i), 15'h0001, 5'b00010, 15'h0, 10'h000);
    end
    clr();
    chk("iarb_cred3", cred(3), 64'd2);
    chk("iarb_cred11", cred(11), 64'd2);

    // Grant and return on the same (o,v)
    set_req(12, 1, 1'b1);
    credit_return[3] = 1'b1;
    cyc("same_cyc", 15'h1000, 5'b00010, 15'h0020, 10'h0);
    clr();
    chk("same_cred", cred(3), 64'd2);
    chk("same_err", 64'(credit_err), 64'h0);

    // Return with counter already full
    credit_return[0] = 1'b1;
    cyc("ovf", 15'h0, 5'h0, 15'h0, 10'h0);
    clr();
    chk("ovf_cred", cred(0), 64'd4);
    chk("ovf_err", 64'(credit_err), 64'h1);
    cyc("ovf_hold", 15'h0, 5'h0, 15'h0, 10'h0);
    chk("ovf_sticky", 64'(credit_err), 64'h1);

    // Reset in the middle of a packet
    set_req(4, 2, 1'b0);
    cyc("pre_rst", 15'h0010, 5'b00100, 15'h0040, 10'h010);
    chk("pre_rst_lock", 64'(out_locked), 64'h04);
    chk("pre_rst_cred", cred(7), 64'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_cred", 64'(credit_count), 64'({15{3'd4}}));
    chk("mid_rst_lock", 64'(out_locked), 64'h0);
    chk("mid_rst_err", 64'(credit_err), 64'h0);
    cyc("in_rst", 15'h0, 5'h0, 15'h0, 10'h0);
    clr();
    reset = 1'b0;

    // Out-of-range route
    set_req(5, 7, 1'b1);
    cyc("badport", 15'h0, 5'h0, 15'h0, 10'h0);
    clr();
    chk("badport_err", 64'(credit_err), 64'h1);

    @(negedge clk);
    #1;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
